bus_txn_arbiter: RTL and testbench

Transaction-aware arbiter that shares the single system bus among up to four masters (data port, instruction fetch, DMA, debug). It replaces the per-cycle owner flip with grants that are held for a whole transaction, parks the grant on the last owner when idle, and adds starvation protection so lower-priority masters are never locked out. It sits between the master request lines and the bus multiplexer select.

---
 rtl/bus_pkg.sv | 18 +
 rtl/arb_pick.sv | 32 +++
 rtl/bus_txn_arbiter.sv | 101 ++++++++++
 tb/tb_bus_txn_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus arbiters: state encoding,
// parameter defaults and the owner-index width helper.
package bus_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam int N_MASTERS_DEF = 2;
   localparam int MAX_WAIT_DEF  = 8;

   // Never returns 0 so a 2-master index still has one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: lowest-index starved candidate if any,
// otherwise lowest-index candidate. Returns one-hot and index forms.
module arb_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  cand,
   input  logic [N-1:0]  starved,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_idx
);

   logic [N-1:0] urgent;
   logic [N-1:0] pool;
   logic         found;

   always_comb begin
      urgent  = cand & starved;
      pool    = (|urgent) ? urgent : cand;
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (pool[i] && !found) begin
            win[i]  = 1'b1;
            win_idx = IW'(i);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_txn_arbiter.sv
// Transaction-holding bus arbiter with grant parking and per-master
// starvation counters; all outputs are flop-driven.
module bus_txn_arbiter
   import bus_pkg::*;
#(
   parameter int N_MASTERS = N_MASTERS_DEF,
   parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_MASTERS-1:0]          req,
   input  logic                          slv_done,
   output logic [N_MASTERS-1:0]          grnt,
   output logic [idx_w(N_MASTERS)-1:0]   owner_id,
   output logic                          bus_busy
);

   localparam int IW = idx_w(N_MASTERS);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [N_MASTERS-1:0] GRNT_RST = {{(N_MASTERS-1){1'b0}}, 1'b1};

   state_t               state, state_nxt;
   logic [N_MASTERS-1:0] cand;
   logic [N_MASTERS-1:0] starved;
   logic [N_MASTERS-1:0] win;
   logic [IW-1:0]        win_idx;
   logic                 owner_req;
   logic                 arb_evt;
   logic                 load;
   logic [CW-1:0]        wait_cnt [N_MASTERS];

   // The finishing owner is excluded so it cannot immediately re-win.
   always_comb begin
      owner_req = |(req & grnt);
      cand      = (state == ST_BUSY) ? (req & ~grnt) : req;
      for (int i = 0; i < N_MASTERS; i++) begin
         starved[i] = (wait_cnt[i] == CW'(MAX_WAIT));
      end
   end

   arb_pick #(
      .N  (N_MASTERS),
      .IW (IW)
   ) u_pick (
      .cand    (cand),
      .starved (starved),
      .win     (win),
      .win_idx (win_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // slv_done takes precedence over a simultaneous owner request drop.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (|req) state_nxt = ST_BUSY;
         ST_BUSY: begin
            if (slv_done)        state_nxt = (|cand) ? ST_BUSY : ST_IDLE;
            else if (!owner_req) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      arb_evt = ((state == ST_IDLE) && (|req)) || ((state == ST_BUSY) && slv_done);
      load    = arb_evt && (|cand);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grnt     <= GRNT_RST;
         owner_id <= '0;
      end else if (load) begin
         grnt     <= win;
         owner_id <= win_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_MASTERS; i++) wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_MASTERS; i++) begin
            if (!req[i]) begin
               wait_cnt[i] <= '0;
            end else if (arb_evt && cand[i]) begin
               if (win[i])                             wait_cnt[i] <= '0;
               else if (wait_cnt[i] != CW'(MAX_WAIT))  wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign bus_busy = (state == ST_BUSY);

endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Directed bench for bus_txn_arbiter: a 2-master instance for reset, parking,
// hand-over, abort and async reset, plus a 3-master instance for starvation.
module tb_bus_txn_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic       slv_done;
   logic [1:0] grnt;
   logic [0:0] owner_id;
   logic       bus_busy;

   logic [2:0] req3;
   logic       done3;
   logic [2:0] grnt3;
   logic [1:0] owner3;
   logic       busy3;

   int checks   = 0;
   int failures = 0;

   bus_txn_arbiter #(.N_MASTERS(2), .MAX_WAIT(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .slv_done (slv_done),
      .grnt     (grnt),
      .owner_id (owner_id),
      .bus_busy (bus_busy)
   );

   bus_txn_arbiter #(.N_MASTERS(3), .MAX_WAIT(2)) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req3),
      .slv_done (done3),
      .grnt     (grnt3),
      .owner_id (owner3),
      .bus_busy (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 2'b11; slv_done = 1'b0; req3 = '0; done3 = 1'b0;
      step(); step();
      checks++;
      if (grnt !== 2'b01 || owner_id !== 1'b0 || bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: grnt=%b owner=%0d busy=%b, need 01/0/0", grnt, owner_id, bus_busy);
      end
      checks++;
      if (grnt3 !== 3'b001 || busy3 !== 1'b0) begin
         failures++;
         $display("FAIL reset_state3: grnt=%b busy=%b, need 001/0", grnt3, busy3);
      end
      rst_n = 1'b1; req = 2'b10;
      step();
      checks++;
      if (grnt !== 2'b10 || owner_id !== 1'b1 || bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL first_grant: grnt=%b owner=%0d busy=%b, need 10/1/1", grnt, owner_id, bus_busy);
      end
   endtask

   task automatic test_parking();
      slv_done = 1'b1;
      step();
      slv_done = 1'b0; req = 2'b00;
      checks++;
      if (grnt !== 2'b10 || bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL park_idle: grnt=%b busy=%b, need 10/0", grnt, bus_busy);
      end
      step();
      checks++;
      if (grnt !== 2'b10 || owner_id !== 1'b1 || bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL park_hold: grnt=%b owner=%0d busy=%b, need 10/1/0", grnt, owner_id, bus_busy);
      end
      req = 2'b10;
      step();
      checks++;
      if (grnt !== 2'b10 || bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL park_regrant: grnt=%b busy=%b, need 10/1", grnt, bus_busy);
      end
      slv_done = 1'b1;
      step();
      slv_done = 1'b0; req = 2'b00;
      step();
   endtask

   task automatic test_handover();
      req = 2'b01;
      step();
      checks++;
      if (grnt !== 2'b01 || owner_id !== 1'b0 || bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL grant_m0: grnt=%b owner=%0d busy=%b, need 01/0/1", grnt, owner_id, bus_busy);
      end
      req = 2'b11;
      step();
      checks++;
      if (grnt !== 2'b01 || bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL hold_txn: grnt=%b busy=%b, need 01/1", grnt, bus_busy);
      end
      slv_done = 1'b1;
      step();
      slv_done = 1'b0; req = 2'b10;
      checks++;
      if (grnt !== 2'b10 || owner_id !== 1'b1 || bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL handover: grnt=%b owner=%0d busy=%b, need 10/1/1", grnt, owner_id, bus_busy);
      end
      slv_done = 1'b1;
      step();
      slv_done = 1'b0; req = 2'b00;
      checks++;
      if (grnt !== 2'b10 || bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL handover_end: grnt=%b busy=%b, need 10/0", grnt, bus_busy);
      end
      step();
   endtask

   task automatic test_abort();
      req = 2'b01;
      step();
      checks++;
      if (grnt !== 2'b01 || bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_grant: grnt=%b busy=%b, need 01/1", grnt, bus_busy);
      end
      req = 2'b00;
      step();
      checks++;
      if (grnt !== 2'b01 || bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle: grnt=%b busy=%b, need 01/0", grnt, bus_busy);
      end
      slv_done = 1'b1;
      step();
      slv_done = 1'b0;
      checks++;
      if (grnt !== 2'b01 || owner_id !== 1'b0 || bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL stray_done: grnt=%b owner=%0d busy=%b, need 01/0/0", grnt, owner_id, bus_busy);
      end
   endtask

   task automatic test_async_reset();
      req = 2'b10;
      step();
      checks++;
      if (grnt !== 2'b10 || bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_busy: grnt=%b busy=%b, need 10/1", grnt, bus_busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (grnt !== 2'b01 || owner_id !== 1'b0 || bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: grnt=%b owner=%0d busy=%b, need 01/0/0", grnt, owner_id, bus_busy);
      end
      req = 2'b00;
      #1 rst_n = 1'b1;
      step();
   endtask

   task automatic test_starvation();
      logic [2:0] exp_g [6];
      logic [1:0] exp_o [6];
      exp_g[0] = 3'b001; exp_o[0] = 2'd0;
      exp_g[1] = 3'b010; exp_o[1] = 2'd1;
      exp_g[2] = 3'b100; exp_o[2] = 2'd2;
      exp_g[3] = 3'b001; exp_o[3] = 2'd0;
      exp_g[4] = 3'b010; exp_o[4] = 2'd1;
      exp_g[5] = 3'b001; exp_o[5] = 2'd0;
      req3 = 3'b111; done3 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         done3 = 1'b1;
         checks++;
         if (grnt3 !== exp_g[k] || owner3 !== exp_o[k] || busy3 !== 1'b1) begin
            failures++;
            $display("FAIL starve_evt%0d: grnt=%b owner=%0d busy=%b, need %b/%0d/1",
                     k, grnt3, owner3, busy3, exp_g[k], exp_o[k]);
         end
      end
      done3 = 1'b0; req3 = 3'b000;
      step();
      checks++;
      if (busy3 !== 1'b0 || grnt3 !== 3'b001) begin
         failures++;
         $display("FAIL starve_park: grnt=%b busy=%b, need 001/0", grnt3, busy3);
      end
   endtask

   initial begin
      test_reset();
      test_parking();
      test_handover();
      test_abort();
      test_async_reset();
      test_starvation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
